// File: rtl/reg_stack_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_stack_file_pkg
// Shared definitions for the register/stack file:
//   - clog2 helper and select / stack-pointer width derivation
//   - stack operation encoding (NONE, PUSH, POP, SWAP)
//   - error-cause constants (OVERFLOW, UNDERFLOW)
// Optional feature macro used elsewhere in this slice: REG_STACK_FILE_BYPASS_EN
// -----------------------------------------------------------------------------
package reg_stack_file_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Register select width; never narrower than one bit.
    function automatic int sel_width(input int num_regs);
        return (num_regs <= 2) ? 1 : clog2(num_regs);
    endfunction

    // Stack pointer counts entries 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return clog2(depth + 1);
    endfunction

    // Stack index width (addresses 0..depth-1).
    function automatic int idx_width(input int depth);
        return (depth <= 2) ? 1 : clog2(depth);
    endfunction

    // Encoding chosen so that {push, pop} maps directly onto the operation.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;

endpackage

// File: rtl/reg_stack_file_if.sv
// -----------------------------------------------------------------------------
// reg_stack_file_if
// Bundles every datapath/control signal of the register/stack file.
//   master : CPU side  (drives strobe, bus data, selects and stack commands)
//   slave  : reg_stack_file (drives read ports and stack status)
// Signals:
//   slow_clock_strb, bus_in, wr_en, mov_en, wr_sel, rd_sel, ra_sel, rb_sel,
//   push, pop, stk_sel, clr_err                        (master -> slave)
//   bus_out, ra_data, rb_data, sp, stk_empty, stk_full, stk_err (slave -> master)
// -----------------------------------------------------------------------------
interface reg_stack_file_if
    import reg_stack_file_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 4,
    parameter int STACK_DEPTH = 8
);
    localparam int SEL_W = sel_width(NUM_REGS);
    localparam int SP_W  = sp_width(STACK_DEPTH);

    logic              slow_clock_strb;
    logic [DATA_W-1:0] bus_in;
    logic              wr_en;
    logic              mov_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [SEL_W-1:0]  rd_sel;
    logic [SEL_W-1:0]  ra_sel;
    logic [SEL_W-1:0]  rb_sel;
    logic              push;
    logic              pop;
    logic [SEL_W-1:0]  stk_sel;
    logic              clr_err;

    logic [DATA_W-1:0] bus_out;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [SP_W-1:0]   sp;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_err;

    modport master (
        output slow_clock_strb, bus_in, wr_en, mov_en, wr_sel, rd_sel,
               ra_sel, rb_sel, push, pop, stk_sel, clr_err,
        input  bus_out, ra_data, rb_data, sp, stk_empty, stk_full, stk_err
    );

    modport slave (
        input  slow_clock_strb, bus_in, wr_en, mov_en, wr_sel, rd_sel,
               ra_sel, rb_sel, push, pop, stk_sel, clr_err,
        output bus_out, ra_data, rb_data, sp, stk_empty, stk_full, stk_err
    );
endinterface

// File: rtl/reg_stack_ctrl.sv
// -----------------------------------------------------------------------------
// reg_stack_ctrl
// Stack bookkeeping: owns the stack pointer, full/empty status and the sticky
// error flag, decodes PUSH/POP/SWAP and tells the storage in the top level
// which stack entry to write and which to read into a register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   strobe                step enable; nothing changes without it
//   push, pop, clr_err    stack commands
//   sp, stk_empty,
//   stk_full, stk_err     status
//   stack_wr, stack_wr_addr   write reg[STK_SEL] into stack entry
//   stack_rd_addr             entry feeding reg[STK_SEL] on pop/swap
//   reg_load                  reg[STK_SEL] takes stack_rd_data this edge
// -----------------------------------------------------------------------------
module reg_stack_ctrl
    import reg_stack_file_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int SP_W        = sp_width(STACK_DEPTH),
    parameter int IDX_W       = idx_width(STACK_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [SP_W-1:0]  sp,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err,
    output logic             stack_wr,
    output logic [IDX_W-1:0] stack_wr_addr,
    output logic [IDX_W-1:0] stack_rd_addr,
    output logic             reg_load
);
    logic [SP_W-1:0] sp_reg;
    logic [SP_W-1:0] sp_next;
    logic            err_reg;
    logic            err_next;
    logic [1:0]      err_cause;
    stack_op_e       op;

    assign stk_empty = (sp_reg == '0);
    assign stk_full  = (sp_reg == SP_W'(STACK_DEPTH));

    // Top of stack lives at sp-1; a plain push lands at sp.
    assign stack_rd_addr = IDX_W'(sp_reg - SP_W'(1));
    assign stack_wr_addr = (op == OP_PUSH) ? IDX_W'(sp_reg) : stack_rd_addr;

    always_comb begin
        op        = strobe ? stack_op_e'({push, pop}) : OP_NONE;
        sp_next   = sp_reg;
        stack_wr  = 1'b0;
        reg_load  = 1'b0;
        err_cause = ERR_NONE;
        case (op)
            OP_PUSH: begin
                if (!stk_full) begin
                    stack_wr = 1'b1;
                    sp_next  = sp_reg + SP_W'(1);
                end else begin
                    err_cause = ERR_OVERFLOW;
                end
            end
            OP_POP: begin
                if (!stk_empty) begin
                    reg_load = 1'b1;
                    sp_next  = sp_reg - SP_W'(1);
                end else begin
                    err_cause = ERR_UNDERFLOW;
                end
            end
            OP_SWAP: begin
                // Exchange top entry with the register; legal even when full.
                if (!stk_empty) begin
                    stack_wr = 1'b1;
                    reg_load = 1'b1;
                end else begin
                    err_cause = ERR_UNDERFLOW;
                end
            end
            default: ;
        endcase
    end

    // A new error wins over a clear requested on the same step.
    always_comb begin
        err_next = err_reg;
        if (strobe) begin
            if (err_cause != ERR_NONE) begin
                err_next = 1'b1;
            end else if (clr_err) begin
                err_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            sp_reg  <= sp_next;
            err_reg <= err_next;
        end
    end

    assign sp      = sp_reg;
    assign stk_err = err_reg;

endmodule

// File: rtl/reg_stack_file.sv
// -----------------------------------------------------------------------------
// reg_stack_file
// NUM_REGS general registers with bus write, immediate move, one bus read port
// and two ALU read ports, plus a STACK_DEPTH-entry hardware register stack.
// All state advances only on rising clk with slow_clock_strb high.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (clears registers, stack, SP, error)
//   bus    reg_stack_file_if.slave (all data/control/status signals)
// Optional: define REG_STACK_FILE_BYPASS_EN to forward the value being written
// on a strobed cycle to bus_out / ra_data / rb_data in the same cycle.
// -----------------------------------------------------------------------------
module reg_stack_file
    import reg_stack_file_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 4,
    parameter int IMM_W       = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_stack_file_if.slave      bus
);
    localparam int SEL_W = sel_width(NUM_REGS);
    localparam int SP_W  = sp_width(STACK_DEPTH);
    localparam int IDX_W = idx_width(STACK_DEPTH);

    logic [DATA_W-1:0] reg_file   [NUM_REGS];
    logic [DATA_W-1:0] reg_next   [NUM_REGS];
    logic [DATA_W-1:0] read_view  [NUM_REGS];
    logic [DATA_W-1:0] stack_mem  [STACK_DEPTH];
    logic [DATA_W-1:0] stack_next [STACK_DEPTH];

    logic              stack_wr;
    logic [IDX_W-1:0]  stack_wr_addr;
    logic [IDX_W-1:0]  stack_rd_addr;
    logic              reg_load;
    logic [SP_W-1:0]   sp;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] stack_rd_data;
    logic [DATA_W-1:0] mov_data;

    reg_stack_ctrl #(
        .STACK_DEPTH (STACK_DEPTH),
        .SP_W        (SP_W),
        .IDX_W       (IDX_W)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .strobe        (bus.slow_clock_strb),
        .push          (bus.push),
        .pop           (bus.pop),
        .clr_err       (bus.clr_err),
        .sp            (sp),
        .stk_empty     (bus.stk_empty),
        .stk_full      (bus.stk_full),
        .stk_err       (bus.stk_err),
        .stack_wr      (stack_wr),
        .stack_wr_addr (stack_wr_addr),
        .stack_rd_addr (stack_rd_addr),
        .reg_load      (reg_load)
    );

    assign bus.sp = sp;

    // Pushed value is always the pre-edge register contents.
    assign push_data     = reg_file[bus.stk_sel];
    assign stack_rd_data = stack_mem[stack_rd_addr];
    assign mov_data      = DATA_W'(bus.bus_in[IMM_W-1:0]);

    // Per-register next value. Priority: pop/swap load, then WR, then MOV.
    // reg_load is already qualified by the strobe inside the controller.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic stk_hit;
            logic wr_hit;
            assign stk_hit = reg_load && (bus.stk_sel == SEL_W'(gi));
            assign wr_hit  = (bus.wr_sel == SEL_W'(gi));
            assign reg_next[gi] = stk_hit                 ? stack_rd_data :
                                  (bus.wr_en  && wr_hit)  ? bus.bus_in    :
                                  (bus.mov_en && wr_hit)  ? mov_data      :
                                                            reg_file[gi];
`ifdef REG_STACK_FILE_BYPASS_EN
            assign read_view[gi] = bus.slow_clock_strb ? reg_next[gi] : reg_file[gi];
`else
            assign read_view[gi] = reg_file[gi];
`endif
        end

        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stk
            assign stack_next[gi] = (stack_wr && (stack_wr_addr == IDX_W'(gi))) ?
                                    push_data : stack_mem[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_file  <= '{default: '0};
            stack_mem <= '{default: '0};
        end else if (bus.slow_clock_strb) begin
            reg_file  <= reg_next;
            stack_mem <= stack_next;
        end
    end

    assign bus.bus_out = read_view[bus.rd_sel];
    assign bus.ra_data = read_view[bus.ra_sel];
    assign bus.rb_data = read_view[bus.rb_sel];

endmodule

// File: tb/tb_reg_stack_file.sv
module tb_reg_stack_file;
    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;
    int step_no;

    // Reference state: plain register array, stack as a queue (back = top).
    logic [15:0] m_regs [4];
    logic [15:0] m_stack [$];
    logic        m_err;

    reg_stack_file_if #(.DATA_W(16), .NUM_REGS(4), .STACK_DEPTH(8)) ifc ();

    reg_stack_file #(
        .DATA_W(16), .NUM_REGS(4), .IMM_W(8), .STACK_DEPTH(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational outputs and status
    // just before the edge, then advance the model on the edge.
    task automatic step(input logic strb, input logic wr, input logic mov,
                        input logic [1:0] wsel, input logic [15:0] bdata,
                        input logic push, input logic pop, input logic [1:0] ssel,
                        input logic clr, input logic [1:0] rsel,
                        input logic [1:0] asel, input logic [1:0] bsel);
        logic [15:0] n_regs [4];
        logic [15:0] n_stack [$];
        logic [15:0] view [4];
        logic [15:0] pre;
        logic [15:0] top;
        logic        n_err;
        logic        err_set;

        @(negedge clk);
        step_no++;
        ifc.slow_clock_strb = strb;
        ifc.wr_en   = wr;
        ifc.mov_en  = mov;
        ifc.wr_sel  = wsel;
        ifc.bus_in  = bdata;
        ifc.push    = push;
        ifc.pop     = pop;
        ifc.stk_sel = ssel;
        ifc.clr_err = clr;
        ifc.rd_sel  = rsel;
        ifc.ra_sel  = asel;
        ifc.rb_sel  = bsel;

        n_regs  = m_regs;
        n_stack = m_stack;
        n_err   = m_err;
        err_set = 1'b0;
        pre     = m_regs[ssel];
        if (strb) begin
            if (wr)       n_regs[wsel] = bdata;
            else if (mov) n_regs[wsel] = {8'h00, bdata[7:0]};
            if (push && !pop) begin
                if (n_stack.size() < 8) n_stack.push_back(pre);
                else err_set = 1'b1;
            end else if (pop && !push) begin
                if (n_stack.size() > 0) n_regs[ssel] = n_stack.pop_back();
                else err_set = 1'b1;
            end else if (push && pop) begin
                if (n_stack.size() > 0) begin
                    top = n_stack[n_stack.size() - 1];
                    n_stack[n_stack.size() - 1] = pre;
                    n_regs[ssel] = top;
                end else begin
                    err_set = 1'b1;
                end
            end
            if (err_set)  n_err = 1'b1;
            else if (clr) n_err = 1'b0;
        end

`ifdef REG_STACK_FILE_BYPASS_EN
        view = strb ? n_regs : m_regs;
`else
        view = m_regs;
`endif

        #1;
        check("bus_out",   32'(ifc.bus_out),   32'(view[rsel]));
        check("ra_data",   32'(ifc.ra_data),   32'(view[asel]));
        check("rb_data",   32'(ifc.rb_data),   32'(view[bsel]));
        check("sp",        32'(ifc.sp),        32'(m_stack.size()));
        check("stk_empty", 32'(ifc.stk_empty), 32'(m_stack.size() == 0));
        check("stk_full",  32'(ifc.stk_full),  32'(m_stack.size() == 8));
        check("stk_err",   32'(ifc.stk_err),   32'(m_err));

        @(posedge clk);
        m_regs  = n_regs;
        m_stack = n_stack;
        m_err   = n_err;
    endtask

    // Idle look at three registers with no strobe.
    task automatic peek(input logic [1:0] rsel, input logic [1:0] asel, input logic [1:0] bsel);
        step(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0, rsel, asel, bsel);
    endtask

    task automatic random_steps(input int n);
        for (int k = 0; k < n; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), 2'($urandom), 16'($urandom),
                 (r < 4), (r >= 3 && r < 7), 2'($urandom), ($urandom_range(0, 7) == 0),
                 2'($urandom), 2'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        step_no      = 0;
        ifc.slow_clock_strb = 1'b0;
        ifc.bus_in  = '0;
        ifc.wr_en   = 1'b0;
        ifc.mov_en  = 1'b0;
        ifc.wr_sel  = '0;
        ifc.rd_sel  = '0;
        ifc.ra_sel  = '0;
        ifc.rb_sel  = '0;
        ifc.push    = 1'b0;
        ifc.pop     = 1'b0;
        ifc.stk_sel = '0;
        ifc.clr_err = 1'b0;
        model_reset();

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        peek(2'd0, 2'd1, 2'd2);
        peek(2'd3, 2'd3, 2'd0);

        // MOV zero-extends the immediate; visible on RA the next cycle
        step(1, 0, 1, 2'd2, 16'hABCD, 0, 0, 2'd0, 0, 2'd2, 2'd2, 2'd0);
        peek(2'd2, 2'd2, 2'd1);
        check("mov_reg2", 32'(ifc.ra_data), 32'h0000_00CD);

        // WR beats MOV; WR without strobe does nothing
        step(1, 1, 1, 2'd1, 16'h1234, 0, 0, 2'd0, 0, 2'd1, 2'd1, 2'd2);
        step(0, 1, 0, 2'd1, 16'hFFFF, 0, 0, 2'd0, 0, 2'd1, 2'd1, 2'd2);
        peek(2'd1, 2'd1, 2'd1);
        check("wr_reg1", 32'(ifc.rb_data), 32'h0000_1234);

        // Fill the stack with 1..8 from reg0, then overflow, then clear
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0, 2'd0, 16'(i), 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
            step(1, 0, 0, 2'd0, 16'h0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
        end
        peek(2'd0, 2'd0, 2'd0);
        step(1, 0, 0, 2'd0, 16'h0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
        peek(2'd0, 2'd0, 2'd0);
        step(1, 0, 0, 2'd0, 16'h0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0);
        peek(2'd0, 2'd0, 2'd0);

        // Pop everything into reg3, then underflow
        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 2'd0, 16'h0, 0, 1, 2'd3, 0, 2'd3, 2'd3, 2'd3);
        peek(2'd3, 2'd3, 2'd3);
        check("last_pop_reg3", 32'(ifc.bus_out), 32'h0000_0001);
        step(1, 0, 0, 2'd0, 16'h0, 0, 1, 2'd3, 0, 2'd3, 2'd3, 2'd3);
        peek(2'd3, 2'd3, 2'd3);

        // Swap with SP=2, top=00AA, reg1=0055
        step(1, 0, 0, 2'd0, 16'h0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0);
        step(1, 1, 0, 2'd0, 16'h0011, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
        step(1, 0, 0, 2'd0, 16'h0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
        step(1, 1, 0, 2'd0, 16'h00AA, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
        step(1, 0, 0, 2'd0, 16'h0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
        step(1, 1, 0, 2'd1, 16'h0055, 0, 0, 2'd0, 0, 2'd1, 2'd1, 2'd1);
        step(1, 0, 0, 2'd0, 16'h0, 1, 1, 2'd1, 0, 2'd1, 2'd1, 2'd0);
        peek(2'd1, 2'd1, 2'd0);
        check("swap_reg1", 32'(ifc.ra_data), 32'h0000_00AA);
        step(1, 0, 0, 2'd0, 16'h0, 0, 1, 2'd2, 0, 2'd2, 2'd2, 2'd2);
        peek(2'd2, 2'd2, 2'd2);
        check("swap_top", 32'(ifc.bus_out), 32'h0000_0055);

        // Same-cycle write with RA selecting the target (forwarded only with bypass)
        step(1, 1, 0, 2'd0, 16'h7777, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0);
        // Push takes pre-edge value while the same register is rewritten
        step(1, 1, 0, 2'd2, 16'h4242, 1, 0, 2'd2, 0, 2'd2, 2'd2, 2'd2);
        // Pop wins over a write to the same register
        step(1, 1, 0, 2'd2, 16'h9999, 0, 1, 2'd2, 0, 2'd2, 2'd2, 2'd2);
        peek(2'd2, 2'd0, 2'd1);

        random_steps(400);

        // Asynchronous reset mid-sequence, no strobe, no clock edge needed
        @(negedge clk);
        ifc.slow_clock_strb = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_bus_out",   32'(ifc.bus_out),   32'h0);
        check("rst_ra_data",   32'(ifc.ra_data),   32'h0);
        check("rst_rb_data",   32'(ifc.rb_data),   32'h0);
        check("rst_sp",        32'(ifc.sp),        32'h0);
        check("rst_stk_empty", 32'(ifc.stk_empty), 32'h1);
        check("rst_stk_full",  32'(ifc.stk_full),  32'h0);
        check("rst_stk_err",   32'(ifc.stk_err),   32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        random_steps(150);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout step=%0d", step_no);
        $fatal(1, "timeout");
    end

endmodule
